// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 FFT controller family.
// State codes, the state enum and a bit-reversal helper.
package fft_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_COMPUTE = 3'd2;
    localparam logic [2:0] ST_FLUSH   = 3'd3;
    localparam logic [2:0] ST_UNLOAD  = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_LOAD    = ST_LOAD,
        S_COMPUTE = ST_COMPUTE,
        S_FLUSH   = ST_FLUSH,
        S_UNLOAD  = ST_UNLOAD,
        S_DONE    = ST_DONE
    } fft_state_t;

    // Reverse the low 'width' bits of value; upper result bits are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < width && i < 32; i++) begin
            r[5'(i)] = value[5'(width - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_r2_scheduler_addr_gen.sv
// fft_r2_addr_gen: combinational DIT butterfly pair and twiddle index from (stage, butterfly).
// Shared with the pipelined FFT, so it holds no state.
module fft_r2_addr_gen #(
    parameter int unsigned LOG2_NFFT = 4,
    parameter int unsigned SW        = 2
) (
    input  logic [SW-1:0]        stage,
    input  logic [LOG2_NFFT-2:0] bfly,
    output logic [LOG2_NFFT-1:0] addr_a,
    output logic [LOG2_NFFT-1:0] addr_b,
    output logic [LOG2_NFFT-2:0] tw_idx
);

    logic [LOG2_NFFT-1:0] k_ext;
    logic [LOG2_NFFT-1:0] half;
    logic [LOG2_NFFT-1:0] pos;
    logic [LOG2_NFFT-1:0] grp;
    logic [LOG2_NFFT-1:0] tw_full;

    // Shift by stage then by one so stage+1 never wraps in SW bits.
    always_comb begin
        k_ext   = LOG2_NFFT'(bfly);
        half    = LOG2_NFFT'(1) << stage;
        pos     = k_ext & (half - LOG2_NFFT'(1));
        grp     = k_ext >> stage;
        addr_a  = ((grp << stage) << 1) | pos;
        addr_b  = addr_a | half;
        tw_full = pos << (SW'(LOG2_NFFT - 1) - stage);
        tw_idx  = tw_full[LOG2_NFFT-2:0];
    end

endmodule

// File: rtl/fft_r2_scheduler.sv
// In-place radix-2 DIT FFT controller: bit-reversed load, staged butterfly issue, natural-order unload.
// Optional FFT_SCALE_EN adds per-stage butterfly scaling (scale_mask in, bf_scale out).
module fft_r2_scheduler
    import fft_pkg::*;
#(
    parameter int unsigned NFFT         = 16,
    parameter int unsigned LOG2_NFFT    = 4,
    parameter int unsigned BFLY_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef FFT_SCALE_EN
    input  logic [LOG2_NFFT-1:0] scale_mask,
    output logic                 bf_scale,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 ld_we,
    output logic [LOG2_NFFT-1:0] ld_addr,
    output logic                 bf_valid,
    output logic [LOG2_NFFT-1:0] bf_addr_a,
    output logic [LOG2_NFFT-1:0] bf_addr_b,
    output logic [LOG2_NFFT-2:0] tw_idx,
    output logic                 wb_we,
    output logic [LOG2_NFFT-1:0] wb_addr_a,
    output logic [LOG2_NFFT-1:0] wb_addr_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LOG2_NFFT-1:0] out_addr,
    output logic                 out_last,
    output logic                 busy,
    output logic                 complete,
    output logic [2:0]           stateFFT
);

    localparam int unsigned SW = (LOG2_NFFT > 1) ? $clog2(LOG2_NFFT) : 1;
    localparam int unsigned FW = $clog2(BFLY_LATENCY + 1);
    localparam int unsigned CW = (LOG2_NFFT > FW) ? LOG2_NFFT : FW;

    fft_state_t      state_q, state_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic [SW-1:0]   stage_q, stage_nxt;

    logic [LOG2_NFFT-1:0] gen_a;
    logic [LOG2_NFFT-1:0] gen_b;
    logic [LOG2_NFFT-2:0] gen_tw;

    logic [BFLY_LATENCY-1:0] wb_pipe_we;
    logic [LOG2_NFFT-1:0]    wb_pipe_a [BFLY_LATENCY];
    logic [LOG2_NFFT-1:0]    wb_pipe_b [BFLY_LATENCY];

`ifdef FFT_SCALE_EN
    logic [LOG2_NFFT-1:0] mask_q;
`endif

    assign ld_we     = in_valid && in_ready;
    assign stateFFT  = state_q;
    assign wb_we     = wb_pipe_we[BFLY_LATENCY-1];
    assign wb_addr_a = wb_pipe_a[BFLY_LATENCY-1];
    assign wb_addr_b = wb_pipe_b[BFLY_LATENCY-1];

    // Addresses are generated from next-state counters so issue outputs can be registered.
    fft_r2_addr_gen #(
        .LOG2_NFFT (LOG2_NFFT),
        .SW        (SW)
    ) u_addr_gen (
        .stage  (stage_nxt),
        .bfly   (cnt_nxt[LOG2_NFFT-2:0]),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    // Next-state and counter logic.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        stage_nxt = stage_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = '0;
                    stage_nxt = '0;
                end
            end
            S_LOAD: begin
                if (in_valid && in_ready) begin
                    if (cnt_q == CW'(NFFT - 1)) begin
                        state_nxt = S_COMPUTE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + CW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (cnt_q == CW'(NFFT / 2 - 1)) begin
                    state_nxt = S_FLUSH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            S_FLUSH: begin
                if (cnt_q == CW'(BFLY_LATENCY - 1)) begin
                    cnt_nxt = '0;
                    if (stage_q == SW'(LOG2_NFFT - 1)) begin
                        state_nxt = S_UNLOAD;
                    end else begin
                        state_nxt = S_COMPUTE;
                        stage_nxt = stage_q + SW'(1);
                    end
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            S_UNLOAD: begin
                if (out_valid && out_ready) begin
                    if (cnt_q == CW'(NFFT - 1)) begin
                        state_nxt = S_DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_q + CW'(1);
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                stage_nxt = '0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            stage_q   <= '0;
            in_ready  <= 1'b0;
            ld_addr   <= '0;
            bf_valid  <= 1'b0;
            bf_addr_a <= '0;
            bf_addr_b <= '0;
            tw_idx    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            complete  <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            stage_q   <= stage_nxt;
            in_ready  <= (state_nxt == S_LOAD);
            ld_addr   <= (state_nxt == S_LOAD) ?
                         LOG2_NFFT'(bitrev(32'(cnt_nxt), LOG2_NFFT)) : '0;
            bf_valid  <= (state_nxt == S_COMPUTE);
            bf_addr_a <= (state_nxt == S_COMPUTE) ? gen_a : '0;
            bf_addr_b <= (state_nxt == S_COMPUTE) ? gen_b : '0;
            tw_idx    <= (state_nxt == S_COMPUTE) ? gen_tw : '0;
            out_valid <= (state_nxt == S_UNLOAD);
            out_addr  <= (state_nxt == S_UNLOAD) ? cnt_nxt[LOG2_NFFT-1:0] : '0;
            out_last  <= (state_nxt == S_UNLOAD) && (cnt_nxt == CW'(NFFT - 1));
            busy      <= (state_nxt != S_IDLE);
            complete  <= (state_nxt == S_DONE);
        end
    end

    // Writeback delay line; cleared on reset so in-flight writebacks are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_pipe_we <= '0;
            for (int i = 0; i < int'(BFLY_LATENCY); i++) begin
                wb_pipe_a[i] <= '0;
                wb_pipe_b[i] <= '0;
            end
        end else begin
            wb_pipe_we[0] <= bf_valid;
            wb_pipe_a[0]  <= bf_addr_a;
            wb_pipe_b[0]  <= bf_addr_b;
            for (int i = 1; i < int'(BFLY_LATENCY); i++) begin
                wb_pipe_we[i] <= wb_pipe_we[i-1];
                wb_pipe_a[i]  <= wb_pipe_a[i-1];
                wb_pipe_b[i]  <= wb_pipe_b[i-1];
            end
        end
    end

`ifdef FFT_SCALE_EN
    // Scale mask is captured with start and applied per stage at issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q   <= '0;
            bf_scale <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                mask_q <= scale_mask;
            end
            bf_scale <= (state_nxt == S_COMPUTE) && mask_q[stage_nxt];
        end
    end
`endif

endmodule

// File: tb/tb_fft_r2_scheduler.sv
// Directed bench for fft_r2_scheduler with NFFT=8, LOG2_NFFT=3, BFLY_LATENCY=2.
// Build with FFT_SCALE_EN defined to also exercise bf_scale.
module tb_fft_r2_scheduler;

    localparam int unsigned NFFT         = 8;
    localparam int unsigned LOG2_NFFT    = 3;
    localparam int unsigned BFLY_LATENCY = 2;

    typedef struct {
        int a;
        int b;
        int tw;
        int scale;
    } bfly_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic                 in_ready, ld_we, bf_valid, wb_we, out_valid, out_last, busy, complete;
    logic [LOG2_NFFT-1:0] ld_addr, bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b, out_addr;
    logic [LOG2_NFFT-2:0] tw_idx;
    logic [2:0]           stateFFT;
`ifdef FFT_SCALE_EN
    logic [LOG2_NFFT-1:0] scale_mask = 3'b101;
    logic                 bf_scale;
`endif

    int checks = 0;
    int errors = 0;

    bfly_vec_t tbl[12];
    int        ld_exp[8];

    fft_r2_scheduler #(
        .NFFT         (NFFT),
        .LOG2_NFFT    (LOG2_NFFT),
        .BFLY_LATENCY (BFLY_LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef FFT_SCALE_EN
        .scale_mask(scale_mask),
        .bf_scale  (bf_scale),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .bf_valid  (bf_valid),
        .bf_addr_a (bf_addr_a),
        .bf_addr_b (bf_addr_b),
        .tw_idx    (tw_idx),
        .wb_we     (wb_we),
        .wb_addr_a (wb_addr_a),
        .wb_addr_b (wb_addr_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .complete  (complete),
        .stateFFT  (stateFFT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, int'(stateFFT), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_bf_valid"}, int'(bf_valid), 0);
        chk({tag, "_bf_addr"}, int'({bf_addr_a, bf_addr_b, tw_idx}), 0);
        chk({tag, "_wb_we"}, int'(wb_we), 0);
        chk({tag, "_wb_addr"}, int'({wb_addr_a, wb_addr_b}), 0);
        chk({tag, "_out"}, int'({out_valid, out_last, out_addr}), 0);
        chk({tag, "_complete"}, int'(complete), 0);
        chk({tag, "_ld_addr"}, int'(ld_addr), 0);
    endtask

    initial begin
        int n, c, cyc, iss, wbn, unload_at, m, p;
        int wb_cyc_q[$];
        int wb_a_q[$];
        int wb_b_q[$];
        bit seen_flush;

        ld_exp = '{0, 4, 2, 6, 1, 5, 3, 7};
        tbl[0]  = '{0, 1, 0, 1};  tbl[1]  = '{2, 3, 0, 1};
        tbl[2]  = '{4, 5, 0, 1};  tbl[3]  = '{6, 7, 0, 1};
        tbl[4]  = '{0, 2, 0, 0};  tbl[5]  = '{1, 3, 2, 0};
        tbl[6]  = '{4, 6, 0, 0};  tbl[7]  = '{5, 7, 2, 0};
        tbl[8]  = '{0, 4, 0, 1};  tbl[9]  = '{1, 5, 1, 1};
        tbl[10] = '{2, 6, 2, 1};  tbl[11] = '{3, 7, 3, 1};

        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk("idle_state", int'(stateFFT), 0);

        // Load with every third cycle gapped; start held high during LOAD must be ignored
        start = 1'b1;
        tick();
        chk("load_entry_state", int'(stateFFT), 1);
        chk("load_busy", int'(busy), 1);
        n = 0;
        c = 0;
        while (n < 8 && c < 40) begin
            in_valid = (c % 3 == 2) ? 1'b0 : 1'b1;
            start    = (c < 4) ? 1'b1 : 1'b0;
            #1;
            if (ld_we) begin
                chk($sformatf("ld_addr[%0d]", n), int'(ld_addr), ld_exp[n]);
                n++;
            end
            tick();
            c++;
        end
        start = 1'b0;
        chk("ld_we_count", n, 8);
        chk("compute_entry_state", int'(stateFFT), 2);
        in_valid = 1'b1;
        #1;
        chk("ld_we_after_load", int'(ld_we), 0);
        in_valid = 1'b0;

        // Compute: issue table, writeback timing, stage-boundary flush
        cyc = 0;
        iss = 0;
        wbn = 0;
        unload_at = -1;
        while (cyc < 40 && unload_at < 0) begin
            if (stateFFT == 3'd4) begin
                unload_at = cyc;
            end else begin
                if (bf_valid) begin
                    if (iss < 12) begin
                        chk($sformatf("bf_a[%0d]", iss), int'(bf_addr_a), tbl[iss].a);
                        chk($sformatf("bf_b[%0d]", iss), int'(bf_addr_b), tbl[iss].b);
                        chk($sformatf("tw[%0d]", iss), int'(tw_idx), tbl[iss].tw);
`ifdef FFT_SCALE_EN
                        chk($sformatf("bf_scale[%0d]", iss), int'(bf_scale), tbl[iss].scale);
`endif
                        wb_cyc_q.push_back(cyc + 2);
                        wb_a_q.push_back(tbl[iss].a);
                        wb_b_q.push_back(tbl[iss].b);
                    end
                    iss++;
                end else begin
`ifdef FFT_SCALE_EN
                    chk("bf_scale_idle", int'(bf_scale), 0);
`endif
                end
                if (wb_we) begin
                    if (wb_cyc_q.size() == 0) begin
                        chk("wb_spurious", 1, 0);
                    end else begin
                        chk($sformatf("wb_cycle[%0d]", wbn), cyc, wb_cyc_q.pop_front());
                        chk($sformatf("wb_a[%0d]", wbn), int'(wb_addr_a), wb_a_q.pop_front());
                        chk($sformatf("wb_b[%0d]", wbn), int'(wb_addr_b), wb_b_q.pop_front());
                    end
                    wbn++;
                end
                tick();
                cyc++;
            end
        end
        chk("unload_entry_cycle", unload_at, 18);
        chk("issue_count", iss, 12);
        chk("wb_count", wbn, 12);

        // Unload with out_ready pattern 1,0,0,1 repeating
        m = 0;
        p = 0;
        while (m < 8 && p < 60) begin
            out_ready = (p % 4 == 0 || p % 4 == 3) ? 1'b1 : 1'b0;
            #1;
            chk($sformatf("out_valid[p%0d]", p), int'(out_valid), 1);
            chk($sformatf("out_addr[p%0d]", p), int'(out_addr), m);
            chk($sformatf("out_last[p%0d]", p), int'(out_last), (m == 7) ? 1 : 0);
            chk($sformatf("unload_wb_we[p%0d]", p), int'(wb_we), 0);
            if (out_ready) m++;
            tick();
            p++;
        end
        out_ready = 1'b0;
        chk("unload_beats", m, 8);
        chk("done_complete", int'(complete), 1);
        chk("done_state", int'(stateFFT), 5);
        chk("done_out_valid", int'(out_valid), 0);
        tick();
        chk("post_done_complete", int'(complete), 0);
        chk("post_done_state", int'(stateFFT), 0);
        chk("post_done_busy", int'(busy), 0);

        // Second run: reset during stage 1 COMPUTE
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        c = 0;
        while (stateFFT != 3'd2 && c < 20) begin
            tick();
            c++;
        end
        in_valid = 1'b0;
        chk("run2_compute_reached", int'(stateFFT), 2);
        seen_flush = 1'b0;
        c = 0;
        while (!(seen_flush && stateFFT == 3'd2) && c < 20) begin
            if (stateFFT == 3'd3) seen_flush = 1'b1;
            tick();
            c++;
        end
        chk("run2_stage1_reached", int'(stateFFT), 2);
        tick();
        chk("run2_stage1_issue", int'(bf_addr_b), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("mid_reset");
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("post_rst_wb_we[%0d]", i), int'(wb_we), 0);
            chk($sformatf("post_rst_state[%0d]", i), int'(stateFFT), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
